// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bus bundle between the instruction fetch unit and its neighbours.
//   Load port : load_valid / load_ready handshake with load_addr, load_data
//   Core port : nextInstructionAddress, pcBranch, halt (from core)
//               instruction, currentInstructionAddress (to core)
// Modports:
//   master : the loader and the core (drive requests and feedback)
//   slave  : the fetch unit (accepts loads, presents instructions)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
);
    logic                load_valid;
    logic                load_ready;
    logic [ADDR_W-1:0]   load_addr;
    logic [INSTR_W-1:0]  load_data;

    logic [ADDR_W-1:0]   nextInstructionAddress;
    logic                pcBranch;
    logic                halt;
    logic [INSTR_W-1:0]  instruction;
    logic [ADDR_W-1:0]   currentInstructionAddress;

    modport master (
        output load_valid, load_addr, load_data,
        output nextInstructionAddress, pcBranch, halt,
        input  load_ready, instruction, currentInstructionAddress
    );

    modport slave (
        input  load_valid, load_addr, load_data,
        input  nextInstructionAddress, pcBranch, halt,
        output load_ready, instruction, currentInstructionAddress
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Upstream neighbour of the single-cycle core. Holds the PC and a small
// instruction memory, accepts memory loads while the core is stopped, and
// after start presents one instruction per executing cycle, taking the
// core's next address back on each executing edge.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   bus        : load port and core port (see instr_fetch_unit_if)
//   start      : begin execution from address 0 (ignored while running)
//   step_mode  : 1 = execute only in cycles where step is high
//   step       : execute one instruction this cycle (step_mode = 1)
//   running    : unit is in RUN
//   halted     : unit is in HALTED
//   retired_count, branch_count : saturating debug counters
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                  ADDR_W  = 5,
    parameter int                  INSTR_W = 16,
    parameter logic [INSTR_W-1:0]  BUBBLE  = '0,
    parameter int                  CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_fetch_unit_if.slave      bus,
    input  logic                   start,
    input  logic                   step_mode,
    input  logic                   step,
    output logic                   running,
    output logic                   halted,
    output logic [CNT_W-1:0]       retired_count,
    output logic [CNT_W-1:0]       branch_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [INSTR_W-1:0]  mem [0:DEPTH-1];
    logic                exec;
    logic                load_fire;

    // The core executes only when running and, in step mode, only on a step.
    assign exec      = (state == RUN) && (!step_mode || step);
    assign load_fire = bus.load_valid && bus.load_ready;

    // Asynchronous read: zero-cycle path from pc to instruction. Outside an
    // executing cycle the core is fed the no-op so it cannot change state.
    assign bus.instruction               = exec ? mem[pc] : BUBBLE;
    assign bus.currentInstructionAddress = pc;
    assign bus.load_ready                = !running;

    // NOTE: the memory array carries no reset so that loaded programs survive
    // a reset pulse and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= '0;
            running       <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
            branch_count  <= '0;
        end else begin
            unique case (state)
                IDLE, HALTED: begin
                    // Starting again from HALTED also clears the debug
                    // counters; in IDLE they are already zero.
                    if (start) begin
                        state         <= RUN;
                        pc            <= '0;
                        running       <= 1'b1;
                        halted        <= 1'b0;
                        retired_count <= '0;
                        branch_count  <= '0;
                    end
                end

                RUN: begin
                    if (exec) begin
                        if (retired_count != '1) begin
                            retired_count <= retired_count + 1'b1;
                        end
                        if (bus.halt) begin
                            // pc is left pointing at the halt instruction.
                            state   <= HALTED;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end else begin
                            pc <= bus.nextInstructionAddress;
                            if (bus.pcBranch && (branch_count != '1)) begin
                                branch_count <= branch_count + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. The bench plays both the memory
// loader and the core. A behavioural model (array memory, integer pc and
// counters) tracks the unit from its rules and is compared every cycle in
// the sequences below; a directed vector table covers load/start/run/halt.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          ADDR_W  = 5;
    localparam int          INSTR_W = 16;
    localparam int          CNT_W   = 8;
    localparam logic [15:0] BUBBLE  = 16'h0000;

    localparam logic [15:0] W0      = 16'h1111;
    localparam logic [15:0] W1      = 16'h2222;
    localparam logic [15:0] W2      = 16'h3333;
    localparam logic [15:0] HALT_W  = 16'hF000;

    logic             clk;
    logic             reset;
    logic             start;
    logic             step_mode;
    logic             step;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] branch_count;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .BUBBLE (BUBBLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .start        (start),
        .step_mode    (step_mode),
        .step         (step),
        .running      (running),
        .halted       (halted),
        .retired_count(retired_count),
        .branch_count (branch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum int { M_IDLE, M_RUN, M_HALTED } m_state_t;

    m_state_t    m_state;
    int          m_pc;
    int          m_ret;
    int          m_br;
    logic [15:0] m_mem [32];

    function automatic bit model_exec();
        return (m_state == M_RUN) && (!step_mode || step);
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_ret   = 0;
        m_br    = 0;
    endfunction

    // Applies one clock edge's worth of rules using the inputs now driven.
    function automatic void model_edge();
        bit ex;
        ex = model_exec();
        if (bus.load_valid && m_state != M_RUN) m_mem[bus.load_addr] = bus.load_data;
        case (m_state)
            M_IDLE, M_HALTED: begin
                if (start) begin
                    m_state = M_RUN;
                    m_pc    = 0;
                    m_ret   = 0;
                    m_br    = 0;
                end
            end
            default: begin
                if (ex) begin
                    m_ret = (m_ret < 255) ? m_ret + 1 : 255;
                    if (bus.halt) begin
                        m_state = M_HALTED;
                    end else begin
                        m_pc = bus.nextInstructionAddress;
                        if (bus.pcBranch) m_br = (m_br < 255) ? m_br + 1 : 255;
                    end
                end
            end
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [15:0] exp_instr;
        exp_instr = model_exec() ? m_mem[m_pc] : BUBBLE;
        check({tag, "/instr"},   32'(bus.instruction), 32'(exp_instr));
        check({tag, "/pc"},      32'(bus.currentInstructionAddress), 32'(m_pc));
        check({tag, "/running"}, 32'(running), 32'(m_state == M_RUN));
        check({tag, "/halted"},  32'(halted), 32'(m_state == M_HALTED));
        check({tag, "/ready"},   32'(bus.load_ready), 32'(m_state != M_RUN));
        check({tag, "/retired"}, 32'(retired_count), 32'(m_ret));
        check({tag, "/branch"},  32'(branch_count), 32'(m_br));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid             = 1'b0;
        bus.load_addr              = '0;
        bus.load_data              = '0;
        bus.nextInstructionAddress = '0;
        bus.pcBranch               = 1'b0;
        bus.halt                   = 1'b0;
        start                      = 1'b0;
        step                       = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        lv;
        logic [4:0]  la;
        logic [15:0] ld;
        logic        st;
        logic [4:0]  nx;
        logic        hl;
        logic [15:0] e_instr;
        logic [4:0]  e_pc;
        logic        e_run;
        logic        e_hlt;
        logic        e_lr;
        logic [7:0]  e_ret;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        int          p0;
        int          a;
        logic [15:0] orig;

        // Inputs, then expected outputs seen before the edge of that cycle.
        vecs[0] = '{1'b1, 5'd0, W0,     1'b0, 5'd0, 1'b0, BUBBLE, 5'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[1] = '{1'b1, 5'd1, W1,     1'b0, 5'd0, 1'b0, BUBBLE, 5'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[2] = '{1'b1, 5'd2, W2,     1'b0, 5'd0, 1'b0, BUBBLE, 5'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{1'b1, 5'd3, HALT_W, 1'b1, 5'd0, 1'b0, BUBBLE, 5'd0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{1'b0, 5'd0, 16'h0,  1'b0, 5'd1, 1'b0, W0,     5'd0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 5'd0, 16'h0,  1'b0, 5'd2, 1'b0, W1,     5'd1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[6] = '{1'b0, 5'd0, 16'h0,  1'b0, 5'd3, 1'b0, W2,     5'd2, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[7] = '{1'b0, 5'd0, 16'h0,  1'b0, 5'd4, 1'b1, HALT_W, 5'd3, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[8] = '{1'b0, 5'd0, 16'h0,  1'b1, 5'd0, 1'b0, BUBBLE, 5'd3, 1'b0, 1'b1, 1'b1, 8'd4};
        vecs[9] = '{1'b0, 5'd0, 16'h0,  1'b0, 5'd1, 1'b0, W0,     5'd0, 1'b1, 1'b0, 1'b0, 8'd0};

        // ---- reset state ----
        idle_inputs();
        step_mode = 1'b0;
        reset     = 1'b0;
        model_reset();
        #1;
        check("rst/instr",   32'(bus.instruction), 32'(BUBBLE));
        check("rst/pc",      32'(bus.currentInstructionAddress), 0);
        check("rst/running", 32'(running), 0);
        check("rst/halted",  32'(halted), 0);
        check("rst/ready",   32'(bus.load_ready), 1);
        check("rst/retired", 32'(retired_count), 0);
        check("rst/branch",  32'(branch_count), 0);
        #13;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---- fill the whole memory so every fetch has a known word ----
        for (int i = 0; i < 32; i++) begin
            bus.load_valid = 1'b1;
            bus.load_addr  = 5'(i);
            bus.load_data  = 16'($urandom);
            tick();
        end
        bus.load_valid = 1'b0;

        // ---- table: load 0..3, start with same-cycle load, run, halt, restart ----
        for (int i = 0; i < 10; i++) begin
            bus.load_valid             = vecs[i].lv;
            bus.load_addr              = vecs[i].la;
            bus.load_data              = vecs[i].ld;
            start                      = vecs[i].st;
            bus.nextInstructionAddress = vecs[i].nx;
            bus.halt                   = vecs[i].hl;
            #1;
            check($sformatf("vec%0d/instr", i),   32'(bus.instruction), 32'(vecs[i].e_instr));
            check($sformatf("vec%0d/pc", i),      32'(bus.currentInstructionAddress), 32'(vecs[i].e_pc));
            check($sformatf("vec%0d/running", i), 32'(running), 32'(vecs[i].e_run));
            check($sformatf("vec%0d/halted", i),  32'(halted), 32'(vecs[i].e_hlt));
            check($sformatf("vec%0d/ready", i),   32'(bus.load_ready), 32'(vecs[i].e_lr));
            check($sformatf("vec%0d/retired", i), 32'(retired_count), 32'(vecs[i].e_ret));
            compare_model($sformatf("vec%0d", i));
            tick();
        end
        idle_inputs();

        // ---- single-step: step every 3rd cycle ----
        step_mode = 1'b1;
        r0 = m_ret;
        p0 = m_pc;
        for (int i = 0; i < 12; i++) begin
            step                       = (i % 3 == 2);
            bus.nextInstructionAddress = 5'(m_pc + 1);
            #1;
            if (!step) check("step/bubble", 32'(bus.instruction), 32'(BUBBLE));
            compare_model("step");
            tick();
        end
        step = 1'b0;
        #1;
        check("step/retired", 32'(retired_count), 32'(r0 + 4));
        check("step/pc",      32'(bus.currentInstructionAddress), 32'((p0 + 4) % 32));
        step_mode = 1'b0;

        // ---- load attempted during RUN is ignored ----
        a    = (m_pc + 1) % 32;
        orig = m_mem[a];
        bus.load_valid             = 1'b1;
        bus.load_addr              = 5'(a);
        bus.load_data              = 16'hFFFF;
        bus.nextInstructionAddress = 5'(a);
        #1;
        check("runload/ready", 32'(bus.load_ready), 0);
        compare_model("runload");
        tick();
        bus.load_valid = 1'b0;
        #1;
        check("runload/instr", 32'(bus.instruction), 32'(orig));
        compare_model("runload2");

        // ---- wrap 31 -> 0 with branch, 300 times; counters saturate ----
        for (int i = 0; i < 300; i++) begin
            bus.nextInstructionAddress = 5'd31;
            bus.pcBranch               = 1'b0;
            #1;
            compare_model("wrapA");
            tick();
            check("wrap/pc31", 32'(bus.currentInstructionAddress), 31);
            bus.nextInstructionAddress = 5'd0;
            bus.pcBranch               = 1'b1;
            #1;
            compare_model("wrapB");
            tick();
            check("wrap/pc0", 32'(bus.currentInstructionAddress), 0);
        end
        bus.pcBranch = 1'b0;
        check("wrap/branch_sat",  32'(branch_count), 32'hFF);
        check("wrap/retired_sat", 32'(retired_count), 32'hFF);

        // ---- asynchronous reset mid-run at pc = 7 ----
        bus.nextInstructionAddress = 5'd7;
        #1;
        compare_model("pre7");
        tick();
        check("pc7", 32'(bus.currentInstructionAddress), 7);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst/instr",   32'(bus.instruction), 32'(BUBBLE));
        check("midrst/pc",      32'(bus.currentInstructionAddress), 0);
        check("midrst/running", 32'(running), 0);
        check("midrst/ready",   32'(bus.load_ready), 1);
        check("midrst/retired", 32'(retired_count), 0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        tick();
        start                      = 1'b0;
        bus.nextInstructionAddress = 5'd1;
        #1;
        check("midrst/mem0_kept", 32'(bus.instruction), 32'(W0));
        compare_model("restart");
        tick();
        #1;
        check("midrst/mem1_kept", 32'(bus.instruction), 32'(W1));

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            if (i % 20 == 0) step_mode = 1'($urandom_range(0, 1));
            bus.load_valid             = 1'($urandom_range(0, 1));
            bus.load_addr              = 5'($urandom);
            bus.load_data              = 16'($urandom);
            start                      = ($urandom_range(0, 7) == 0);
            step                       = 1'($urandom_range(0, 1));
            bus.nextInstructionAddress = 5'($urandom);
            bus.pcBranch               = 1'($urandom_range(0, 1));
            bus.halt                   = ($urandom_range(0, 15) == 0);
            #1;
            compare_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle core.
- Owns the 5-bit PC and a 32x16 instruction memory.
- Memory is loaded through a valid/ready port while the core is stopped.
- After start, presents one instruction per executing cycle and takes the core's next address back.
- Supports free-run and single-step modes, stops on the core's halt, and keeps retired/branch counters for debug and verification.

Parameters:
- ADDR_W, 5, PC and load address width (memory depth 2**ADDR_W).
- INSTR_W, 16, instruction width.
- BUBBLE, 16'h0000, team no-op encoding: no register write, no memory write, no branch, no halt. Driven whenever the core must not execute.
- CNT_W, 8, width of the debug counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  load word offered.
- load_ready  out  1  unit accepts a load this cycle.
- load_addr  in  ADDR_W  memory word address for the load.
- load_data  in  INSTR_W  instruction word for the load.
- start  in  1  begin execution from address 0.
- step_mode  in  1  1 = execute only on step cycles.
- step  in  1  execute exactly one instruction this cycle (step_mode=1 only).
- nextInstructionAddress  in  ADDR_W  next PC from core.
- pcBranch  in  1  core reports branch taken.
- halt  in  1  core decoded halt.
- instruction  out  INSTR_W  instruction to core.
- currentInstructionAddress  out  ADDR_W  current PC to core.
- running  out  1  state == RUN.
- halted  out  1  state == HALTED.
- retired_count  out  CNT_W  executed instructions, saturating.
- branch_count  out  CNT_W  taken branches, saturating.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (asynchronous, reset low):
  - State = IDLE, pc = 0, counters = 0.
  - All outputs derive from this state: instruction = BUBBLE, currentInstructionAddress = 0, running = 0, halted = 0, load_ready = 1.
  - Memory array has no reset; contents survive reset.
- exec (combinational) = (state == RUN) && (!step_mode || step).
- Outputs:
  - instruction = exec ? mem[pc] : BUBBLE. Memory read is asynchronous.
  - currentInstructionAddress = pc at all times.
- load_ready = (state != RUN).
  - Write occurs when load_valid && load_ready, at the clock edge, into mem[load_addr].
  - The word is readable from the next cycle.
  - load_valid while in RUN is ignored; no write, no error.
- IDLE:
  - start -> RUN, pc <= 0.
  - A load and start in the same cycle: both take effect. The first executed fetch sees the new word.
- RUN with exec = 1, per clock edge:
  - If halt: -> HALTED; pc holds (points at the halt instruction); retired_count increments.
  - Else: pc <= nextInstructionAddress; retired_count increments; branch_count increments if pcBranch.
- RUN with exec = 0 (stepping, no step): pc and counters hold; the core sees BUBBLE.
- start while in RUN is ignored.
- HALTED: start -> RUN, pc <= 0, both counters cleared. Loads are allowed in HALTED.
- PC wrap: 31 -> 0 arrives from the core as a plain ADDR_W value; no special handling.
- Counters saturate at all-ones and never wrap.
- halt and pcBranch are sampled only when exec = 1. Outside exec they are don't-care.
- Latency:
  - Zero cycles from pc to instruction.
  - One clock edge from nextInstructionAddress to pc.
  - One edge from start to the first executed instruction.
- Reset asserted mid-run: immediate return to IDLE with outputs as above; the core sees BUBBLE combinationally.

Test Plan:
- Reset, load mem[0..3] via 4 valid/ready beats, start; core next addresses 1,2,3 -> instruction sequence mem[0],mem[1],mem[2],mem[3] on consecutive cycles; retired_count = 3 before the halt cycle.
- mem[3] = halt encoding -> halted = 1 the cycle after pc = 3, pc stays 3, instruction = BUBBLE, retired_count = 4. Then start -> pc = 0, counters = 0.
- step_mode = 1, step pulsed every 3rd cycle -> instruction = BUBBLE on non-step cycles, pc advances only on step edges, retired_count equals the step count.
- load_valid asserted during RUN with load_data = 16'hFFFF at pc+1 -> load_ready = 0, memory unchanged, next fetch returns the original word.
- Core returns nextInstructionAddress = 0 from pc = 31 with pcBranch = 1, repeated 300 times -> pc = 0 each time, branch_count saturates at 8'hFF.
- Reset pulsed low mid-run at pc = 7 -> asynchronous IDLE, pc = 0, instruction = BUBBLE; previously loaded words still readable after a new start.
